// File: rtl/apb_pkg.sv
// Shared types and constants for the APB rev C master bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    RSP_OKAY    = 2'b00,
    RSP_SLVERR  = 2'b01,
    RSP_DECERR  = 2'b10,
    RSP_TIMEOUT = 2'b11
  } rsp_code_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } bridge_state_e;

  localparam int unsigned PPROT_PRIV   = 0;
  localparam int unsigned PPROT_NONSEC = 1;
  localparam int unsigned PPROT_INSTR  = 2;

  // Slave-index width; a single slave still needs one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_slave_decoder.sv
// Address-region decoder: picks the slave index and flags indices with no slave.
module apb_slave_decoder
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned REGION_LSB = 12,
  localparam int unsigned SEL_W     = sel_width(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [SEL_W-1:0]      idx,
  output logic                  dec_err
);

  // Only the region field matters; the rest of the address is ignored here.
  logic unused_addr;
  assign unused_addr = ^addr;

  assign idx     = addr[REGION_LSB +: SEL_W];
  assign dec_err = (32'(idx) >= NUM_SLAVES);

endmodule

// File: rtl/apb_rev_c_master_bridge.sv
// Valid/ready command stream to APB rev C master with one-hot select decode,
// slave response mux and an ACCESS-phase wait-state timeout.
module apb_rev_c_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned REGION_LSB     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             pclk,
  input  logic                             preset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
  input  logic [2:0]                       cmd_prot,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [1:0]                       rsp_code,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [2:0]                       pprot,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int unsigned STRB_W    = DATA_WIDTH / 8;
  localparam int unsigned SEL_W     = sel_width(NUM_SLAVES);
  localparam int unsigned CNT_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  bridge_state_e          state_q, state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  rsp_code_e              rsp_code_q, rsp_code_d;
  logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic [2:0]             pprot_q, pprot_d;
  logic [NUM_SLAVES-1:0]  psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic [STRB_W-1:0]      pstrb_q, pstrb_d;
  logic [SEL_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [SEL_W-1:0]       dec_idx;
  logic                   dec_err;
  logic [NUM_SLAVES-1:0]  dec_onehot;
  logic                   sel_ready;
  logic                   sel_err;
  logic [DATA_WIDTH-1:0]  sel_rdata;

  apb_slave_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .REGION_LSB (REGION_LSB)
  ) u_dec (
    .addr    (cmd_addr),
    .idx     (dec_idx),
    .dec_err (dec_err)
  );

  // One-hot select for the decoded slave and response mux for the latched one.
  always_comb begin
    dec_onehot = '0;
    sel_ready  = 1'b0;
    sel_err    = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec_onehot[i] = (dec_idx == SEL_W'(i));
      if (idx_q == SEL_W'(i)) begin
        sel_ready = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_code_d  = rsp_code_q;
    paddr_d     = paddr_q;
    pprot_d     = pprot_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          paddr_d     = cmd_addr;
          pwrite_d    = cmd_write;
          pwdata_d    = cmd_wdata;
          pprot_d     = {cmd_prot[PPROT_INSTR], cmd_prot[PPROT_NONSEC], cmd_prot[PPROT_PRIV]};
          idx_d       = dec_idx;
          if (dec_err) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_code_d  = RSP_DECERR;
            rsp_rdata_d = '0;
          end else begin
            state_d = ST_SETUP;
            psel_d  = dec_onehot;
            pstrb_d = cmd_write ? cmd_strb : '0;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ST_ACCESS: begin
        // A pready on the limit cycle takes priority over the timeout.
        if (sel_ready) begin
          state_d     = ST_RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          pstrb_d     = '0;
          rsp_valid_d = 1'b1;
          rsp_code_d  = sel_err ? RSP_SLVERR : RSP_OKAY;
          rsp_rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : '0;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT)) begin
          state_d     = ST_RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          pstrb_d     = '0;
          rsp_valid_d = 1'b1;
          rsp_code_d  = RSP_TIMEOUT;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_code_q  <= RSP_OKAY;
      paddr_q     <= '0;
      pprot_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_code_q  <= rsp_code_d;
      paddr_q     <= paddr_d;
      pprot_q     <= pprot_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_code  = rsp_code_q;
  assign paddr     = paddr_q;
  assign pprot     = pprot_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;

endmodule
